// File: rtl/test_pattern_pkg.sv
// Shared types and constants for the test pattern generator.
package test_pattern_pkg;

  typedef enum logic [2:0] {
    BORDER  = 3'd0,
    BARS    = 3'd1,
    CHECKER = 3'd2,
    RAMP    = 3'd3,
    BOX     = 3'd4
  } pattern_t;

  // Colour bars left to right; entry 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

endpackage

// File: rtl/box_motion.sv
// Bouncing box position: one pixel per frame on each axis, reflecting off the screen edges.
module box_motion #(
  parameter int BIT_WIDTH = 10,
  parameter int BOX_SIZE  = 32
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 fb,
  input  logic [BIT_WIDTH-1:0] screen_width,
  input  logic [BIT_WIDTH-1:0] screen_height,
  output logic [BIT_WIDTH-1:0] box_x,
  output logic [BIT_WIDTH-1:0] box_y
);

  localparam logic [BIT_WIDTH-1:0] ONE     = BIT_WIDTH'(1);
  localparam logic [BIT_WIDTH:0]   BOX_EXT = (BIT_WIDTH+1)'(BOX_SIZE);

  logic [BIT_WIDTH-1:0] r_box_x, r_box_y;
  logic                 r_dir_x, r_dir_y;  // 1 = moving towards larger coordinates
  logic [BIT_WIDTH:0]   w_x_lim, w_y_lim;
  logic                 w_dir_x_d, w_dir_y_d;
  logic [BIT_WIDTH-1:0] w_box_x_d, w_box_y_d;

  // Flip direction at an edge, then step one pixel in the (possibly new) direction.
  always_comb begin
    w_x_lim   = {1'b0, screen_width} - BOX_EXT;
    w_y_lim   = {1'b0, screen_height} - BOX_EXT;
    w_dir_x_d = r_dir_x;
    w_dir_y_d = r_dir_y;
    if (r_dir_x ? ({1'b0, r_box_x} == w_x_lim) : (r_box_x == '0)) w_dir_x_d = ~r_dir_x;
    if (r_dir_y ? ({1'b0, r_box_y} == w_y_lim) : (r_box_y == '0)) w_dir_y_d = ~r_dir_y;
    w_box_x_d = w_dir_x_d ? r_box_x + ONE : r_box_x - ONE;
    w_box_y_d = w_dir_y_d ? r_box_y + ONE : r_box_y - ONE;
  end

  // Position only moves at the frame boundary so a frame is drawn with one position.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_box_x <= '0;
      r_box_y <= '0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (fb) begin
      r_box_x <= w_box_x_d;
      r_box_y <= w_box_y_d;
      r_dir_x <= w_dir_x_d;
      r_dir_y <= w_dir_y_d;
    end
  end

  assign box_x = r_box_x;
  assign box_y = r_box_y;

endmodule

// File: rtl/test_pattern_gen.sv
// Per-pixel test pattern source with frame-synchronous pattern switching and registered output.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int          BIT_WIDTH = 10,
  parameter int          BOX_SIZE  = 32,
  parameter logic [23:0] BOX_COLOR = 24'hFFFFFF
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic [BIT_WIDTH-1:0] cy,
  input  logic [BIT_WIDTH-1:0] screen_width,
  input  logic [BIT_WIDTH-1:0] screen_height,
  input  logic [BIT_WIDTH-1:0] frame_width,
  input  logic [BIT_WIDTH-1:0] frame_height,
  input  logic [2:0]           pattern_select,
  output logic [23:0]          rgb,
  output logic [2:0]           active_pattern,
  output logic [15:0]          frame_count
);

  localparam logic [BIT_WIDTH-1:0] ONE     = BIT_WIDTH'(1);
  localparam logic [BIT_WIDTH:0]   BOX_EXT = (BIT_WIDTH+1)'(BOX_SIZE);

  logic [23:0]          r_rgb;
  logic [2:0]           r_active_pattern;
  logic [15:0]          r_frame_count;
  logic [BIT_WIDTH-1:0] r_bar_pos;
  logic [2:0]           r_bar_idx;

  logic                 w_fb, w_active, w_in_box;
  logic [BIT_WIDTH-1:0] w_box_x, w_box_y, w_bar_w, w_bar_pos;
  logic [2:0]           w_bar_idx;
  logic [23:0]          w_rgb;

  box_motion #(
    .BIT_WIDTH(BIT_WIDTH),
    .BOX_SIZE (BOX_SIZE)
  ) u_box_motion (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .fb           (w_fb),
    .screen_width (screen_width),
    .screen_height(screen_height),
    .box_x        (w_box_x),
    .box_y        (w_box_y)
  );

  // Pixel classification and current bar position (counter restarts at the start of each line).
  always_comb begin
    w_fb      = (cx == frame_width - ONE) && (cy == frame_height - ONE);
    w_active  = (cx < screen_width) && (cy < screen_height);
    w_bar_w   = screen_width >> 3;
    w_bar_pos = (cx == '0) ? '0 : r_bar_pos;
    w_bar_idx = (cx == '0) ? 3'd0 : r_bar_idx;
    w_in_box  = ({1'b0, cx} >= {1'b0, w_box_x}) && ({1'b0, cx} < {1'b0, w_box_x} + BOX_EXT) &&
                ({1'b0, cy} >= {1'b0, w_box_y}) && ({1'b0, cy} < {1'b0, w_box_y} + BOX_EXT);
  end

  // Bar counter: advance the index every bar_width pixels, saturating at bar 7 for leftovers.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_bar_pos <= '0;
      r_bar_idx <= 3'd0;
    end else if ((w_bar_idx != 3'd7) && (w_bar_pos == w_bar_w - ONE)) begin
      r_bar_pos <= '0;
      r_bar_idx <= w_bar_idx + 3'd1;
    end else begin
      r_bar_pos <= w_bar_pos + ONE;
      r_bar_idx <= w_bar_idx;
    end
  end

  // Colour for the presented pixel under the currently latched pattern.
  always_comb begin
    w_rgb = 24'h000000;
    if (w_active) begin
      case (r_active_pattern)
        BORDER: begin
          if (cx == '0) w_rgb[23:16] = 8'hFF;
          if (cy == '0) w_rgb[15:8] = 8'hFF;
          if ((cx == screen_width - ONE) || (cy == screen_height - ONE)) w_rgb[7:0] = 8'hFF;
        end
        BARS:    w_rgb = BAR_COLORS[w_bar_idx];
        CHECKER: w_rgb = (cx[5] ^ cy[5]) ? 24'hFFFFFF : 24'h000000;
        RAMP:    w_rgb = {3{cx[9:2]}};
        BOX:     w_rgb = w_in_box ? BOX_COLOR : 24'h000000;
        default: w_rgb = 24'h000000;
      endcase
    end
  end

  // Output register, pattern latch and frame counter; the latter two only change at fb.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_rgb            <= 24'h000000;
      r_active_pattern <= 3'd0;
      r_frame_count    <= 16'h0000;
    end else begin
      r_rgb <= w_rgb;
      if (w_fb) begin
        r_active_pattern <= pattern_select;
        r_frame_count    <= r_frame_count + 16'h0001;
      end
    end
  end

  assign rgb            = r_rgb;
  assign active_pattern = r_active_pattern;
  assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed, table-driven bench for test_pattern_gen (640x480 and 1284x480 geometries).
module tb_test_pattern_gen;

  typedef struct {
    logic [2:0]  pat;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    int          x;
    logic [23:0] exp;
  } bar_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cx = 10'd700, cy = 10'd500;
  logic [2:0]  sel = 3'd0;
  logic [23:0] rgb;
  logic [2:0]  ap;
  logic [15:0] fc;

  logic [10:0] cx_b = 11'd1400, cy_b = 11'd500;
  logic [2:0]  sel_b = 3'd0;
  logic [23:0] rgb_b;
  logic [2:0]  ap_b;
  logic [15:0] fc_b;

  int errs = 0;
  int checks = 0;
  int exp_fc = 0;

  vec_t vecs[$];
  bar_t bars[$];
  bar_t bars_b[$];

  always #5 clk = ~clk;

  test_pattern_gen u_dut (
    .clk_pixel     (clk),
    .reset         (rst),
    .cx            (cx),
    .cy            (cy),
    .screen_width  (10'd640),
    .screen_height (10'd480),
    .frame_width   (10'd800),
    .frame_height  (10'd525),
    .pattern_select(sel),
    .rgb           (rgb),
    .active_pattern(ap),
    .frame_count   (fc)
  );

  test_pattern_gen #(
    .BIT_WIDTH(11)
  ) u_dut_b (
    .clk_pixel     (clk),
    .reset         (rst),
    .cx            (cx_b),
    .cy            (cy_b),
    .screen_width  (11'd1284),
    .screen_height (11'd480),
    .frame_width   (11'd1600),
    .frame_height  (11'd525),
    .pattern_select(sel_b),
    .rgb           (rgb_b),
    .active_pattern(ap_b),
    .frame_count   (fc_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one pixel for one cycle; returns just after the edge that registers its colour.
  task automatic probe(input int x, input int y);
    @(negedge clk);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic probe_chk(input int x, input int y, input logic [23:0] exp);
    probe(x, y);
    chk($sformatf("rgb(%0d,%0d)", x, y), {8'h0, rgb}, {8'h0, exp});
  endtask

  // One frame-boundary cycle, then park on a harmless blanking coordinate.
  task automatic frame();
    probe(799, 524);
    exp_fc++;
    cx = 10'd700;
    cy = 10'd500;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic add_vec(input logic [2:0] p, input int x, input int y, input logic [23:0] e);
    vec_t v;
    v.pat = p;
    v.x = x;
    v.y = y;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic add_bar(input int which, input int x, input logic [23:0] e);
    bar_t b;
    b.x = x;
    b.exp = e;
    if (which == 0) bars.push_back(b);
    else bars_b.push_back(b);
  endtask

  initial begin
    logic [2:0] cur;

    add_vec(3'd0, 0, 0, 24'hFFFF00);
    add_vec(3'd0, 639, 10, 24'h0000FF);
    add_vec(3'd0, 10, 479, 24'h0000FF);
    add_vec(3'd0, 10, 0, 24'h00FF00);
    add_vec(3'd0, 100, 100, 24'h000000);
    add_vec(3'd0, 0, 479, 24'hFF00FF);
    add_vec(3'd0, 639, 0, 24'h00FFFF);
    add_vec(3'd0, 700, 100, 24'h000000);
    add_vec(3'd0, 100, 500, 24'h000000);
    add_vec(3'd2, 32, 0, 24'hFFFFFF);
    add_vec(3'd2, 0, 32, 24'hFFFFFF);
    add_vec(3'd2, 32, 32, 24'h000000);
    add_vec(3'd2, 0, 0, 24'h000000);
    add_vec(3'd2, 700, 100, 24'h000000);
    add_vec(3'd2, 100, 500, 24'h000000);
    add_vec(3'd3, 0, 5, 24'h000000);
    add_vec(3'd3, 4, 5, 24'h010101);
    add_vec(3'd3, 639, 5, 24'h9F9F9F);
    add_vec(3'd3, 700, 100, 24'h000000);
    add_vec(3'd3, 100, 500, 24'h000000);
    add_vec(3'd1, 700, 100, 24'h000000);
    add_vec(3'd1, 100, 500, 24'h000000);
    add_vec(3'd4, 700, 100, 24'h000000);
    add_vec(3'd4, 100, 500, 24'h000000);
    add_vec(3'd6, 0, 0, 24'h000000);
    add_vec(3'd6, 32, 0, 24'h000000);
    add_vec(3'd6, 320, 240, 24'h000000);
    add_vec(3'd6, 639, 479, 24'h000000);
    add_vec(3'd5, 10, 0, 24'h000000);
    add_vec(3'd7, 0, 0, 24'h000000);

    add_bar(0, 0, 24'hFFFFFF);
    add_bar(0, 79, 24'hFFFFFF);
    add_bar(0, 80, 24'hFFFF00);
    add_bar(0, 160, 24'h00FFFF);
    add_bar(0, 240, 24'h00FF00);
    add_bar(0, 320, 24'hFF00FF);
    add_bar(0, 400, 24'hFF0000);
    add_bar(0, 559, 24'h0000FF);
    add_bar(0, 560, 24'h000000);
    add_bar(0, 639, 24'h000000);
    add_bar(1, 0, 24'hFFFFFF);
    add_bar(1, 160, 24'hFFFF00);
    add_bar(1, 1119, 24'h0000FF);
    add_bar(1, 1120, 24'h000000);
    add_bar(1, 1280, 24'h000000);
    add_bar(1, 1283, 24'h000000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", {8'h0, rgb}, 32'h0);
    chk("reset_ap", {29'h0, ap}, 32'h0);
    chk("reset_fc", {16'h0, fc}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // One-cycle latency: the colour is not visible before the registering edge
    probe_chk(100, 100, 24'h000000);
    @(negedge clk);
    cx = 10'd0;
    cy = 10'd0;
    #1;
    chk("latency_pre", {8'h0, rgb}, 32'h0);
    @(posedge clk);
    #1;
    chk("latency_post", {8'h0, rgb}, 32'h00FFFF00);

    // Table sweep over patterns, switching at a frame boundary when needed
    cur = 3'd0;
    foreach (vecs[i]) begin
      if (vecs[i].pat != cur) begin
        sel = vecs[i].pat;
        frame();
        cur = vecs[i].pat;
        chk($sformatf("ap_switch_%0d", cur), {29'h0, ap}, {29'h0, cur});
      end
      probe_chk(vecs[i].x, vecs[i].y, vecs[i].exp);
    end
    chk("fc_after_table", {16'h0, fc}, exp_fc);

    // Pattern latch: select changes away from fb are ignored
    sel = 3'd0;
    frame();
    sel = 3'd3;
    probe_chk(10, 0, 24'h00FF00);
    chk("latch_hold_ap", {29'h0, ap}, 32'h0);
    sel = 3'd2;
    probe_chk(639, 10, 24'h0000FF);
    chk("latch_hold_ap2", {29'h0, ap}, 32'h0);
    frame();
    chk("latch_ap_after_fb", {29'h0, ap}, 32'h2);
    sel = 3'd0;
    probe_chk(32, 0, 24'hFFFFFF);
    probe_chk(0, 0, 24'h000000);
    chk("latch_ap_stays", {29'h0, ap}, 32'h2);

    // Bars: two consecutive lines so the counter must restart at cx==0
    sel = 3'd1;
    frame();
    sel = 3'd0;
    for (int line = 0; line < 2; line++) begin
      for (int x = 0; x < 640; x++) begin
        probe(x, 10 + line);
        foreach (bars[k]) begin
          if (bars[k].x == x) begin
            chk($sformatf("bar_l%0d_x%0d", line, x), {8'h0, rgb}, {8'h0, bars[k].exp});
          end
        end
      end
    end
    cx = 10'd700;
    cy = 10'd500;

    // Bars on a 1284-wide screen: leftover columns stay in bar 7
    @(negedge clk);
    cx_b = 11'd1599;
    cy_b = 11'd524;
    sel_b = 3'd1;
    @(posedge clk);
    #1;
    chk("b_ap", {29'h0, ap_b}, 32'h1);
    for (int x = 0; x < 1284; x++) begin
      @(negedge clk);
      cx_b = 11'(x);
      cy_b = 11'd20;
      @(posedge clk);
      #1;
      foreach (bars_b[k]) begin
        if (bars_b[k].x == x) begin
          chk($sformatf("bar_b_x%0d", x), {8'h0, rgb_b}, {8'h0, bars_b[k].exp});
        end
      end
    end
    @(negedge clk);
    cx_b = 11'd1400;
    cy_b = 11'd500;

    // Reset in the middle of frame 37 while a non-black pattern is shown
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;
    sel = 3'd3;
    frames(37);
    chk("fc_37", {16'h0, fc}, 32'd37);
    @(negedge clk);
    cx = 10'd300;
    cy = 10'd100;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rgb", {8'h0, rgb}, 32'h0);
    chk("midrst_fc", {16'h0, fc}, 32'h0);
    chk("midrst_ap", {29'h0, ap}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cx = 10'd700;
    cy = 10'd500;
    exp_fc = 0;

    // Box: first fb after reset latches BOX and moves the box from (0,0) to (1,1)
    sel = 3'd4;
    frame();
    chk("box_ap", {29'h0, ap}, 32'h4);
    probe_chk(0, 0, 24'h000000);
    probe_chk(1, 1, 24'hFFFFFF);
    probe_chk(32, 32, 24'hFFFFFF);
    probe_chk(33, 32, 24'h000000);
    probe_chk(32, 33, 24'h000000);

    // Frame 448: box at (448,448), y at its limit
    frames(447);
    probe_chk(448, 448, 24'hFFFFFF);
    probe_chk(479, 479, 24'hFFFFFF);
    probe_chk(448, 447, 24'h000000);
    probe_chk(447, 448, 24'h000000);
    // Frame 449: y flips, box at (449,447)
    frame();
    probe_chk(449, 447, 24'hFFFFFF);
    probe_chk(449, 478, 24'hFFFFFF);
    probe_chk(449, 479, 24'h000000);

    // Frame 608: box at (608,288), x at its limit
    frames(159);
    probe_chk(639, 288, 24'hFFFFFF);
    probe_chk(608, 319, 24'hFFFFFF);
    probe_chk(607, 288, 24'h000000);
    probe_chk(608, 287, 24'h000000);
    probe_chk(608, 320, 24'h000000);
    probe_chk(640, 288, 24'h000000);
    // Frame 609: x flips, box at (607,287)
    frame();
    probe_chk(607, 287, 24'hFFFFFF);
    probe_chk(638, 318, 24'hFFFFFF);
    probe_chk(639, 287, 24'h000000);
    chk("fc_609", {16'h0, fc}, exp_fc);

    // Frame counter wrap from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frames(65535);
    chk("fc_ffff", {16'h0, fc}, 32'h0000FFFF);
    frame();
    chk("fc_wrap", {16'h0, fc}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
